proc_io_ctrl: RTL and testbench

Handshake sequencer between the Processor's IN/OUT instruction execution and its external byte-wide I/O pins. The block converts single-level processor requests into 4-phase handshakes on `in`/`inDataReady`/`inACK` and `out`/`outDataReady`/`outACK`. It stalls the core until each transfer completes. It sits inside Processor, between the control FSM and the top-level I/O ports.

---
 rtl/proc_io_pkg.sv | 10 +
 rtl/proc_io_if.sv | 11 +
 rtl/proc_io_timeout.sv | 19 +
 rtl/proc_io_ctrl.sv | 82 ++++++++
 tb/tb_proc_io_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/proc_io_pkg.sv
// proc_io_pkg: state encoding and parameter defaults shared by the I/O handshake sequencer
package proc_io_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_DROP = 3'd2;
  localparam logic [2:0] WR_ACK = 3'd3;
  localparam logic [2:0] WR_DROP = 3'd4;
endpackage

// File: rtl/proc_io_if.sv
// proc_io_if: external byte-wide 4-phase I/O pins; master is the sequencer, slave the host side
interface proc_io_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic inDataReady;
  logic inACK;
  logic outDataReady;
  logic outACK;
  modport master(input in, inDataReady, outACK, output inACK, out, outDataReady);
  modport slave(output in, inDataReady, outACK, input inACK, out, outDataReady);
endinterface

// File: rtl/proc_io_timeout.sv
// proc_io_timeout: 16-bit wait-state counter with clear/enable and an expiry flag
module proc_io_timeout
  import proc_io_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + 16'd1;
  end
  assign expired = cnt == 16'(LIMIT);
endmodule

// File: rtl/proc_io_ctrl.sv
// proc_io_ctrl: turns level IN/OUT requests into 4-phase pin handshakes and stalls the core meanwhile
// Wait-state abort with io_err is compiled in by PROC_IO_TIMEOUT_EN
module proc_io_ctrl
  import proc_io_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
`ifdef PROC_IO_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              io_done,
  output logic              io_err,
  output logic              stall,
  proc_io_if.master         io
);
  logic [2:0] state, stateNext;
  logic capture, abort;
  always_comb begin
    stateNext = state;
    capture = 1'b0;
    case (state)
      IDLE: if (!io_done) begin
        if (wr_req) stateNext = WR_ACK;
        else if (rd_req) begin
          stateNext = io.inDataReady ? RD_DROP : RD_WAIT;
          capture = io.inDataReady;
        end
      end
      RD_WAIT: if (io.inDataReady) begin
        stateNext = RD_DROP;
        capture = 1'b1;
      end
      RD_DROP: stateNext = io.inDataReady ? RD_DROP : IDLE;
      WR_ACK: stateNext = io.outACK ? WR_DROP : WR_ACK;
      WR_DROP: stateNext = io.outACK ? WR_DROP : IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort) begin
      stateNext = IDLE;
      capture = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_data <= '0;
      io.out <= '0;
      io.inACK <= 1'b0;
      io.outDataReady <= 1'b0;
      io_done <= 1'b0;
    end else begin
      state <= stateNext;
      io_done <= abort || (state == RD_DROP && !io.inDataReady) || (state == WR_DROP && !io.outACK);
      if (capture) rd_data <= io.in;
      if (state == IDLE && stateNext == WR_ACK) io.out <= wr_data;
      io.inACK <= stateNext == RD_DROP;
      io.outDataReady <= stateNext == WR_ACK;
    end
  end
`ifdef PROC_IO_TIMEOUT_EN
  logic expired;
  proc_io_timeout #(.LIMIT(TIMEOUT_CYC)) uTimeout (
    .clk(clk),
    .reset(reset),
    .clr(stateNext != state || state == IDLE),
    .en(state != IDLE),
    .expired(expired)
  );
  assign abort = expired && state != IDLE;
  always_ff @(posedge clk) io_err <= reset ? 1'b0 : abort;
`else
  assign abort = 1'b0;
  assign io_err = 1'b0;
`endif
  assign stall = (rd_req | wr_req) & ~io_done;
endmodule

// File: tb/tb_proc_io_ctrl.sv
// tb_proc_io_ctrl: directed vectors for the I/O handshake sequencer
module tb_proc_io_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd_req = 1'b0;
  logic wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic io_done, io_err, stall;
  int passCnt = 0;
  int checkCnt = 0;
  proc_io_if #(.DATA_W(8)) io ();
  proc_io_ctrl #(
    .DATA_W(8)
`ifdef PROC_IO_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd_req(rd_req),
    .wr_req(wr_req),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .io_done(io_done),
    .io_err(io_err),
    .stall(stall),
    .io(io)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    io.in = 8'h00;
    io.inDataReady = 1'b0;
    io.outACK = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_out", io.out, 8'h00);
    check("rst_inACK", io.inACK, 1'b0);
    check("rst_outDataReady", io.outDataReady, 1'b0);
    check("rst_io_done", io_done, 1'b0);
    check("rst_io_err", io_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("idle_stall", stall, 1'b0);
      check("idle_io_done", io_done, 1'b0);
      step();
    end
    // read with data already presented
    io.in = 8'hA5;
    io.inDataReady = 1'b1;
    rd_req = 1'b1;
    #1 check("rd_stall_T", stall, 1'b1);
    step();
    check("rd_inACK_T1", io.inACK, 1'b1);
    check("rd_done_T1", io_done, 1'b0);
    io.inDataReady = 1'b0;
    #1 check("rd_stall_T1", stall, 1'b1);
    step();
    check("rd_done_T2", io_done, 1'b1);
    check("rd_err_T2", io_err, 1'b0);
    check("rd_inACK_T2", io.inACK, 1'b0);
    check("rd_data", rd_data, 8'hA5);
    check("rd_stall_T2", stall, 1'b0);
    rd_req = 1'b0;
    step();
    check("rd_done_pulse", io_done, 1'b0);
    // write
    wr_data = 8'h3C;
    wr_req = 1'b1;
    step();
    check("wr_odr_T1", io.outDataReady, 1'b1);
    check("wr_out_T1", io.out, 8'h3C);
    io.outACK = 1'b1;
    step();
    check("wr_odr_T2", io.outDataReady, 1'b0);
    check("wr_done_T2", io_done, 1'b0);
    io.outACK = 1'b0;
    step();
    check("wr_done_T3", io_done, 1'b1);
    check("wr_err_T3", io_err, 1'b0);
    check("wr_stall_T3", stall, 1'b0);
    wr_req = 1'b0;
    step();
    check("wr_done_pulse", io_done, 1'b0);
    check("wr_out_hold", io.out, 8'h3C);
    // simultaneous requests: write wins, read follows
    io.in = 8'h5A;
    io.inDataReady = 1'b1;
    wr_data = 8'hC3;
    rd_req = 1'b1;
    wr_req = 1'b1;
    step();
    check("sim_odr_T1", io.outDataReady, 1'b1);
    check("sim_inACK_T1", io.inACK, 1'b0);
    check("sim_out_T1", io.out, 8'hC3);
    io.outACK = 1'b1;
    step();
    check("sim_odr_T2", io.outDataReady, 1'b0);
    io.outACK = 1'b0;
    step();
    check("sim_wdone_T3", io_done, 1'b1);
    check("sim_inACK_T3", io.inACK, 1'b0);
    wr_req = 1'b0;
    step();
    check("sim_done_T4", io_done, 1'b0);
    check("sim_inACK_T4", io.inACK, 1'b0);
    step();
    check("sim_inACK_T5", io.inACK, 1'b1);
    check("sim_done_T5", io_done, 1'b0);
    io.inDataReady = 1'b0;
    step();
    check("sim_rdone_T6", io_done, 1'b1);
    check("sim_rd_data", rd_data, 8'h5A);
    rd_req = 1'b0;
    step();
    check("sim_done_pulse", io_done, 1'b0);
    // read through wait states, request dropped before completion
    io.in = 8'h81;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_inACK", io.inACK, 1'b0);
      check("wait_stall", stall, 1'b1);
    end
    io.inDataReady = 1'b1;
    step();
    check("wait_inACK_up", io.inACK, 1'b1);
    rd_req = 1'b0;
    io.inDataReady = 1'b0;
    step();
    check("wait_done", io_done, 1'b1);
    check("wait_rd_data", rd_data, 8'h81);
    step();
    check("wait_done_pulse", io_done, 1'b0);
`ifdef PROC_IO_TIMEOUT_EN
    io.in = 8'hEE;
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("to_wait_done", io_done, 1'b0);
    end
    step();
    check("to_done", io_done, 1'b1);
    check("to_err", io_err, 1'b1);
    check("to_rd_data", rd_data, 8'h81);
    rd_req = 1'b0;
    step();
    check("to_done_pulse", io_done, 1'b0);
`endif
    // reset in the middle of a write
    wr_data = 8'h77;
    wr_req = 1'b1;
    step();
    check("rw_odr_T1", io.outDataReady, 1'b1);
    reset = 1'b1;
    wr_req = 1'b0;
    step();
    check("rw_odr_rst", io.outDataReady, 1'b0);
    check("rw_done_rst", io_done, 1'b0);
    check("rw_out_rst", io.out, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rw_done_after", io_done, 1'b0);
      check("rw_odr_after", io.outDataReady, 1'b0);
    end
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
